// File: rtl/aes_reg_status_multi.sv
// Multi-group register write-status tracker with a valid/ready completion-event channel.
// Each group tracks which of its sub-registers are written and reports fresh/clean/error status.
module aes_reg_status_multi #(
  parameter int NumCh   = 2,
  parameter int Width   = 4,
  parameter int InOrder = 0,
  parameter int ChW     = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumCh*Width-1:0] we_i,
  input  logic [NumCh-1:0]       use_i,
  input  logic [NumCh-1:0]       clear_i,
  input  logic [NumCh-1:0]       arm_i,
  output logic [NumCh-1:0]       new_o,
  output logic [NumCh-1:0]       new_pulse_o,
  output logic [NumCh-1:0]       clean_o,
  output logic [NumCh-1:0]       err_o,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [ChW-1:0]         evt_ch_o,
  output logic                   evt_ovf_o
);

  logic [NumCh-1:0][Width-1:0] we_q, we_d;
  logic [NumCh-1:0] armed_q, armed_d;
  logic [NumCh-1:0] new_q, new_d;
  logic [NumCh-1:0] clean_q, clean_d;
  logic [NumCh-1:0] err_q, err_d;

  logic [NumCh-1:0] pend_q, pend_d;
  logic [NumCh-1:0] pop;
  logic             sel_valid_q, sel_valid_d;
  logic [ChW-1:0]   sel_ch_q, sel_ch_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             load;
  logic             any_pend;
  logic [ChW-1:0]   pick_ch;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    logic [Width-1:0] wei;
    logic [Width-1:0] acc;
    logic             any_we;
    logic             ofault;
    logic             kill;

    assign wei    = we_i[c*Width +: Width];
    assign any_we = |wei;
    // An armed group restarts tracking from the first new write.
    assign acc    = (armed_q[c] && any_we) ? wei : (we_q[c] | wei);

    if (InOrder != 0) begin : g_ord
      assign ofault = any_we && ((acc & (acc + Width'(1))) != '0);
    end else begin : g_any
      assign ofault = 1'b0;
    end

    assign kill       = clear_i[c] | use_i[c] | ofault;
    assign we_d[c]    = kill ? '0 : acc;
    assign armed_d[c] = (clear_i[c] | use_i[c] | (armed_q[c] & any_we)) ?
                        1'b0 : (armed_q[c] | arm_i[c]);
    assign new_d[c]   = kill ? 1'b0 : (&we_d[c]);
    assign clean_d[c] = (clear_i[c] | ofault) ? 1'b0 :
                        (&we_d[c])            ? 1'b1 :
                        (we_d[c] == '0)       ? clean_q[c] : 1'b0;
    assign err_d[c]   = ofault | (err_q[c] & ~clear_i[c]);
  end

  assign new_pulse_o = new_d & ~new_q;
  assign new_o       = new_q;
  assign clean_o     = clean_q;
  assign err_o       = err_q;

  assign accept   = sel_valid_q & evt_ready_i;
  assign load     = ~sel_valid_q | accept;
  assign any_pend = |pend_q;

  always_comb begin
    pick_ch = '0;
    for (int i = NumCh - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        pick_ch = ChW'(i);
      end
    end
  end

  // Lowest set pending bit is the one handed to the output register.
  assign pop = load ? (pend_q & (~pend_q + NumCh'(1))) : '0;

  assign pend_d      = new_pulse_o | (pend_q & ~pop & ~clear_i);
  assign ovf_d       = ovf_q | (|(new_pulse_o & pend_q & ~pop));
  assign sel_valid_d = load ? any_pend : sel_valid_q;
  assign sel_ch_d    = (load && any_pend) ? pick_ch : sel_ch_q;

  assign evt_valid_o = sel_valid_q;
  assign evt_ch_o    = sel_ch_q;
  assign evt_ovf_o   = ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q        <= '0;
      armed_q     <= '0;
      new_q       <= '0;
      clean_q     <= '0;
      err_q       <= '0;
      pend_q      <= '0;
      sel_valid_q <= 1'b0;
      sel_ch_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      we_q        <= we_d;
      armed_q     <= armed_d;
      new_q       <= new_d;
      clean_q     <= clean_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      sel_valid_q <= sel_valid_d;
      sel_ch_q    <= sel_ch_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: doc/aes_reg_status_multi.md
AES_REG_STATUS_MULTI -- requirements
Module: aes_reg_status_multi

Interface
REQ-001 SHALL have parameter NumCh, default 2, meaning number of independent tracked register groups (1..16).
REQ-002 SHALL have parameter Width, default 4, meaning sub-registers per group (1..32).
REQ-003 SHALL have parameter InOrder, default 0, meaning 1 = sub-registers of a group must be written in ascending index order.
REQ-004 SHALL have parameter ChW = max(1, clog2(NumCh)), meaning width of the channel index.
REQ-005 SHALL have port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port we_i, input, NumCh*Width, per-sub-register write strobes; group c uses bits [c*Width +: Width].
REQ-008 SHALL have ports use_i, clear_i and arm_i, each input, NumCh, per-group consume, invalidate and arm-restart requests.
REQ-009 SHALL have ports new_o, new_pulse_o, clean_o and err_o, each output, NumCh, per-group status.
REQ-010 SHALL have ports evt_valid_o (output, 1), evt_ready_i (input, 1) and evt_ch_o (output, ChW), the completion-event valid/ready channel.
REQ-011 SHALL have port evt_ovf_o, output, 1, sticky event-loss flag.

Function (per group c; the *_q values are registered state)
REQ-012 SHALL compute acc = we_q | we_i, or we_i alone when armed_q=1 and |we_i=1.
REQ-013 SHALL set order-fault ofault=1 when InOrder=1, |we_i=1 and acc is not of form 2^k-1; with InOrder=0, ofault SHALL be 0.
REQ-014 SHALL set we_d = 0 if clear_i, use_i or ofault is 1, else acc.
REQ-015 SHALL set armed_d = 0 if clear_i, use_i or (armed_q and |we_i) is 1, else armed_q|arm_i.
REQ-016 SHALL set new_d = 0 if clear_i, use_i or ofault is 1, else &we_d.
REQ-017 SHALL set clean_d: 0 if clear_i or ofault; else 1 if &we_d; else clean_q if we_d==0; else 0.
REQ-018 SHALL hold err_q sticky: set by ofault, cleared only by clear_i; clear_i and ofault in the same cycle SHALL leave err_q=1.
REQ-019 SHALL drive new_o=new_q, clean_o=clean_q, err_o=err_q, and new_pulse_o=new_d&~new_q (combinational).
REQ-020 SHALL keep groups fully independent; activity in one group SHALL NOT affect another group's status.

Function (event reporting)
REQ-021 SHALL keep a pending bit per group, set at the edge where new_pulse_o[c]=1.
REQ-022 SHALL hold the presented event in registers: sel_valid_q drives evt_valid_o and sel_ch_q drives evt_ch_o.
REQ-023 SHALL, when sel_valid_q=0 or the event is accepted (evt_valid_o & evt_ready_i), load at the next edge the lowest-index pending group into sel_ch_q and clear its pending bit; sel_valid_q SHALL be 1 iff any group was pending.
REQ-024 SHALL hold evt_ch_o and evt_valid_o stable while evt_valid_o=1 and evt_ready_i=0.
REQ-025 SHALL give latency: new_o[c] first high in cycle N gives evt_valid_o high no earlier than N+1; back-to-back accepts SHALL sustain one event per cycle.
REQ-026 SHALL let clear_i[c] clear pending[c] unless the same edge sets it; an event already presented SHALL NOT be withdrawn by clear_i.
REQ-027 SHALL set evt_ovf_o (sticky until reset) when a group's pending bit is to be set while it is already 1; the event SHALL be merged, not queued twice.
REQ-028 SHALL allow a group that is currently presented to hold one further pending event without overflow.

Reset
REQ-029 SHALL, while rst_ni=0, clear we_q, armed_q, new_q, clean_q, err_q, pending, sel_valid_q, sel_ch_q and evt_ovf_o to 0.
REQ-030 SHALL hold all outputs at 0 during reset, except new_pulse_o, which follows its combinational equation.
REQ-031 SHALL, on reset assertion mid-handshake, drop evt_valid_o immediately and lose all pending events.

Verification
REQ-032 SHALL cover: NumCh=2, Width=4, InOrder=0; group 0 writes bits 3,1,0,2 in separate cycles -> new_o[0]=1 and clean_o[0]=1 the cycle after bit 2, new_pulse_o[0] one cycle, evt_valid_o=1 evt_ch_o=0 one cycle later.
REQ-033 SHALL cover: InOrder=1; write bit0 then bit2 -> err_o=1, new_o=0, clean_o=0, we_q cleared; clear_i -> err_o=0.
REQ-034 SHALL cover: both groups complete in the same cycle with evt_ready_i=1 -> events ch0 then ch1 on consecutive cycles, evt_ovf_o=0.
REQ-035 SHALL cover: evt_ready_i=0; group 1 completes, is used, then completes twice more -> first presented, second pending, third sets evt_ovf_o=1.
REQ-036 SHALL cover: arm_i then partial write of bit1 after a full write -> tracking restarts with we_q=0010, new_o=0, clean_o=0.
REQ-037 SHALL cover: rst_ni low while evt_valid_o=1 -> all outputs 0 asynchronously, and no event reappears after release.
